// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package ifetch_pkg;

    localparam int XLEN         = 32;
    localparam int IFETCH_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Reservation queue for in-flight fetches: entries are allocated at issue,
// filled in order as responses arrive and drained in order to decode.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = IFETCH_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             alloc_i,
    input  logic [XLEN-1:0]  alloc_pc_i,
    input  logic             fill_i,
    input  logic [XLEN-1:0]  fill_data_i,
    input  logic             deq_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] pending_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     entries_q [DEPTH];
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] fl_q;
    logic [PTR_W-1:0] head_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] ptrGap;

    // Equal fill and alloc pointers are ambiguous only when the queue is full;
    // then fl sits on head, and head's filled flag tells all-pending from none.
    assign ptrGap    = tail_q - fl_q;
    assign pending_o = (ptrGap != '0) ? {1'b0, ptrGap} :
                       ((count_q == DEPTH_C && !entries_q[head_q].filled) ? DEPTH_C : '0);

    assign head_o  = entries_q[head_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            tail_q  <= '0;
            fl_q    <= '0;
            head_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].filled <= 1'b0;
            end
            tail_q  <= head_q;
            fl_q    <= head_q;
            count_q <= '0;
        end else begin
            if (alloc_i) begin
                entries_q[tail_q].pc     <= alloc_pc_i;
                entries_q[tail_q].filled <= 1'b0;
                tail_q                   <= tail_q + 1'b1;
            end
            if (fill_i) begin
                entries_q[fl_q].inst   <= fill_data_i;
                entries_q[fl_q].filled <= 1'b1;
                fl_q                   <= fl_q + 1'b1;
            end
            if (deq_i) begin
                entries_q[head_q].filled <= 1'b0;
                head_q                   <= head_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(alloc_i) - CNT_W'(deq_i);
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch front end: issues in-order imem reads for the current PC,
// queues responses for decode, and squashes stale fetches on a redirect.
module ifetch
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = IFETCH_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] pc_cur_i,
    output logic            pc_hold_o,
    input  logic            flush_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_data_o,
    output logic [XLEN-1:0] inst_pc_o
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);

    fetch_entry_t     head;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] dropCnt_q;
    logic [CNT_W-1:0] dropCnt_d;
    logic [CNT_W:0]   credit;
    logic [CNT_W:0]   owed;
    logic             fire;
    logic             deq;
    logic             rspDrop;
    logic             rspFill;

    // Squashed fetches still hold a slot until their response comes back.
    assign credit           = {1'b0, count} + {1'b0, dropCnt_q};
    assign imem_req_valid_o = rst_ni && !flush_i && (credit < DEPTH_W);
    assign imem_req_addr_o  = pc_cur_i;
    assign fire             = imem_req_valid_o && imem_req_ready_i;
    assign pc_hold_o        = !rst_ni || (!fire && !flush_i);

    assign inst_valid_o = rst_ni && head.filled && (count != '0) && !flush_i;
    assign inst_data_o  = head.inst;
    assign inst_pc_o    = head.pc;
    assign deq          = inst_valid_o && inst_ready_i;

    assign rspDrop = imem_rsp_valid_i && (dropCnt_q != '0);
    assign rspFill = imem_rsp_valid_i && (dropCnt_q == '0) && (pending != '0) && !flush_i;

    // On a flush every unfilled entry becomes a response to throw away,
    // less the one arriving in the flush cycle itself.
    assign owed = {1'b0, dropCnt_q} + {1'b0, pending};

    always_comb begin
        dropCnt_d = dropCnt_q;
        if (flush_i) begin
            if (imem_rsp_valid_i && owed != '0) begin
                dropCnt_d = CNT_W'(owed - 1'b1);
            end else begin
                dropCnt_d = CNT_W'(owed);
            end
        end else if (rspDrop) begin
            dropCnt_d = dropCnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dropCnt_q <= '0;
        end else begin
            dropCnt_q <= dropCnt_d;
        end
    end

    ifetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .alloc_i     (fire),
        .alloc_pc_i  (pc_cur_i),
        .fill_i      (rspFill),
        .fill_data_i (imem_rsp_data_i),
        .deq_i       (deq),
        .head_o      (head),
        .count_o     (count),
        .pending_o   (pending)
    );

    rsp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(imem_rsp_valid_i && dropCnt_q == '0 && pending == '0));

    counts_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (count <= DEPTH_C) && (dropCnt_q <= DEPTH_C));

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: the bench plays PC and a 1-cycle imem,
// predicting every delivered {pc, instruction} pair in order.
module tb_ifetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pcCur;
    logic        pcHold;
    logic        flush;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        rspValid;
    logic [31:0] rspData;
    logic        instValid;
    logic        instReady;
    logic [31:0] instData;
    logic [31:0] instPc;

    logic [63:0] sb[$];
    logic [31:0] memQ[$];
    logic        memStall;
    logic [31:0] flushTarget;
    logic        lastDeq;
    logic [31:0] lastDeqPc;
    int          total;
    int          bad;
    int          delivered;

    ifetch dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .pc_cur_i         (pcCur),
        .pc_hold_o        (pcHold),
        .flush_i          (flush),
        .imem_req_valid_o (reqValid),
        .imem_req_ready_i (reqReady),
        .imem_req_addr_o  (reqAddr),
        .imem_rsp_valid_i (rspValid),
        .imem_rsp_data_i  (rspData),
        .inst_valid_o     (instValid),
        .inst_ready_i     (instReady),
        .inst_data_o      (instData),
        .inst_pc_o        (instPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of the environment: check issue/delivery, then advance memory and PC.
    task automatic cycle();
        logic        fire;
        logic        hold;
        logic        fl;
        logic [63:0] exp;
        #1;
        fire    = reqValid && reqReady;
        hold    = pcHold;
        fl      = flush;
        lastDeq = 1'b0;
        if (fire) begin
            total++;
            if (reqAddr !== pcCur) begin
                bad++;
                $display("[TB] FAIL req_addr: got %h want %h", reqAddr, pcCur);
            end
            sb.push_back({pcCur, pcCur ^ 32'hA5A50000});
            memQ.push_back(reqAddr);
        end
        if (instValid && instReady) begin
            lastDeq   = 1'b1;
            lastDeqPc = instPc;
            delivered++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL deliver_unexpected: got pc=%h data=%h want nothing", instPc, instData);
            end else begin
                exp = sb.pop_front();
                if ({instPc, instData} !== exp) begin
                    bad++;
                    $display("[TB] FAIL deliver: got pc=%h data=%h want pc=%h data=%h",
                             instPc, instData, exp[63:32], exp[31:0]);
                end
            end
        end
        if (fl) sb.delete();
        @(posedge clk);
        #1;
        rspValid = 1'b0;
        rspData  = '0;
        if (memQ.size() > 0 && !memStall) begin
            rspValid = 1'b1;
            rspData  = memQ.pop_front() ^ 32'hA5A50000;
        end
        if (fl) pcCur = flushTarget;
        else if (!hold) pcCur = pcCur + 32'd4;
        flush = 1'b0;
    endtask

    task automatic applyReset(input logic [31:0] startPc);
        rst_n    = 1'b0;
        flush    = 1'b0;
        rspValid = 1'b0;
        rspData  = '0;
        memStall = 1'b0;
        sb.delete();
        memQ.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        pcCur = startPc;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; reqReady = 1'b1; instReady = 1'b1;
        pcCur = 32'h0; rspValid = 1'b0; rspData = '0; memStall = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        total += 3;
        if (reqValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_valid: got %b want 0", reqValid); end
        if (instValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_inst_valid: got %b want 0", instValid); end
        if (pcHold !== 1'b1) begin bad++; $display("[TB] FAIL reset_pc_hold: got %b want 1", pcHold); end
        rst_n = 1'b1;
        #1;
        total += 3;
        if (reqValid !== 1'b1) begin bad++; $display("[TB] FAIL release_req_valid: got %b want 1", reqValid); end
        if (reqAddr !== 32'h0) begin bad++; $display("[TB] FAIL release_addr: got %h want 0", reqAddr); end
        if (pcHold !== 1'b0) begin bad++; $display("[TB] FAIL release_pc_hold: got %b want 0", pcHold); end
    endtask

    task automatic test_streaming();
        int start;
        start = delivered;
        for (int i = 0; i < 12; i++) cycle();
        total++;
        if (delivered - start != 10) begin
            bad++;
            $display("[TB] FAIL stream_rate: got %0d deliveries want 10", delivered - start);
        end
    endtask

    task automatic test_backpressure();
        int start;
        applyReset(32'h0);
        instReady = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        #1;
        total += 5;
        if (reqValid !== 1'b0) begin bad++; $display("[TB] FAIL full_req_valid: got %b want 0", reqValid); end
        if (pcHold !== 1'b1) begin bad++; $display("[TB] FAIL full_pc_hold: got %b want 1", pcHold); end
        if (pcCur !== 32'h10) begin bad++; $display("[TB] FAIL full_pc_frozen: got %h want 10", pcCur); end
        if (instValid !== 1'b1) begin bad++; $display("[TB] FAIL full_inst_valid: got %b want 1", instValid); end
        if (instPc !== 32'h0) begin bad++; $display("[TB] FAIL full_head_pc: got %h want 0", instPc); end
        instReady = 1'b1;
        start = delivered;
        for (int i = 0; i < 8; i++) cycle();
        total++;
        if (delivered - start != 8) begin
            bad++;
            $display("[TB] FAIL drain_count: got %0d want 8", delivered - start);
        end
    endtask

    task automatic test_redirect();
        bit found;
        applyReset(32'h0);
        instReady = 1'b1;
        cycle();
        cycle();
        memStall = 1'b1;
        cycle();
        cycle();
        flush       = 1'b1;
        flushTarget = 32'h1000;
        memStall    = 1'b0;
        #1;
        total += 2;
        if (instValid !== 1'b0) begin bad++; $display("[TB] FAIL flush_inst_valid: got %b want 0", instValid); end
        if (reqValid !== 1'b0) begin bad++; $display("[TB] FAIL flush_req_valid: got %b want 0", reqValid); end
        cycle();
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            found = lastDeq;
        end
        total++;
        if (!found || lastDeqPc !== 32'h1000) begin
            bad++;
            $display("[TB] FAIL redirect_first_pc: got %h (seen=%0b) want 00001000", lastDeqPc, found);
        end
    endtask

    task automatic test_flush_rsp();
        int  waitCycles;
        bit  found;
        applyReset(32'h0);
        instReady = 1'b0;
        cycle();
        cycle();
        flush       = 1'b1;
        flushTarget = 32'h2000;
        instReady   = 1'b1;
        #1;
        total += 2;
        if (instValid !== 1'b0) begin bad++; $display("[TB] FAIL flushrsp_no_handshake: got %b want 0", instValid); end
        if (rspValid !== 1'b1) begin bad++; $display("[TB] FAIL flushrsp_setup_rsp: got %b want 1", rspValid); end
        cycle();
        found      = 1'b0;
        waitCycles = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found      = lastDeq;
            waitCycles = i;
        end
        total += 2;
        if (!found || lastDeqPc !== 32'h2000) begin
            bad++;
            $display("[TB] FAIL flushrsp_first_pc: got %h (seen=%0b) want 00002000", lastDeqPc, found);
        end
        if (waitCycles != 2) begin
            bad++;
            $display("[TB] FAIL flushrsp_latency: got %0d want 2", waitCycles);
        end
    endtask

    task automatic test_reset_midstream();
        int start;
        applyReset(32'h0);
        instReady = 1'b0;
        cycle();
        cycle();
        cycle();
        #1;
        total++;
        if (instValid !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_valid: got %b want 1", instValid); end
        rst_n = 1'b0;
        #1;
        total += 3;
        if (instValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_inst_valid: got %b want 0", instValid); end
        if (pcHold !== 1'b1) begin bad++; $display("[TB] FAIL mid_pc_hold: got %b want 1", pcHold); end
        if (reqValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_req_valid: got %b want 0", reqValid); end
        sb.delete();
        memQ.delete();
        rspValid = 1'b0;
        @(posedge clk);
        #1;
        pcCur     = 32'h40;
        instReady = 1'b1;
        rst_n     = 1'b1;
        #1;
        total += 3;
        if (instValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_empty: got %b want 0", instValid); end
        if (reqValid !== 1'b1) begin bad++; $display("[TB] FAIL mid_restart_valid: got %b want 1", reqValid); end
        if (reqAddr !== 32'h40) begin bad++; $display("[TB] FAIL mid_restart_addr: got %h want 40", reqAddr); end
        start = delivered;
        for (int i = 0; i < 5; i++) cycle();
        total++;
        if (delivered - start != 3) begin
            bad++;
            $display("[TB] FAIL mid_restart_count: got %0d want 3", delivered - start);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        delivered = 0;
        lastDeq   = 1'b0;
        lastDeqPc = '0;
        flushTarget = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_flush_rsp();
        test_reset_midstream();
        total++;
        if (sb.size() > 4) begin
            bad++;
            $display("[TB] FAIL leftover: got %0d expected entries want <=4", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
